// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter/sequencer for the core's single data-memory bus.
// Master 0 is the CPU datapath, master 1 the auxiliary master (boot loader, debug, DMA).
// Transactions are serialised and read data is returned only to the master that issued the read.
//
// Build option: ARB_CPU_PRIORITY_EN
//   defined   -> fixed priority, the CPU wins every tie
//   undefined -> round-robin between the two masters
//
// Ports
//   iCLK, iRST                       clock; asynchronous active-high reset
//   iCpu*/iAux* Req,Write,Addr,WData,BE   master requests, held until the matching ready
//   oCpuReady/oAuxReady              request accepted this cycle
//   oCpuRValid/oAuxRValid            one-cycle read-data strobe
//   oCpuRData/oAuxRData              read data, zero unless RValid
//   oCpuStall                        CPU must wait: request not accepted, or its read still outstanding
//   oMem*                            memory bus towards the RAM; iMemReadData comes back from it
//   oOwner                           00 idle, 01 CPU read outstanding, 10 AUX read outstanding
module mem_bus_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCpuReq,
    input  logic              iAuxReq,
    input  logic              iCpuWrite,
    input  logic              iAuxWrite,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [ADDR_W-1:0] iAuxAddr,
    input  logic [31:0]       iCpuWData,
    input  logic [31:0]       iAuxWData,
    input  logic [3:0]        iCpuBE,
    input  logic [3:0]        iAuxBE,
    output logic              oCpuReady,
    output logic              oAuxReady,
    output logic              oCpuRValid,
    output logic              oAuxRValid,
    output logic [31:0]       oCpuRData,
    output logic [31:0]       oAuxRData,
    output logic              oCpuStall,
    output logic [ADDR_W-1:0] oMemAddress,
    output logic [31:0]       oMemWriteData,
    output logic [3:0]        oMemByteEnable,
    output logic              oMemWriteEnable,
    output logic              oMemReadEnable,
    input  logic [31:0]       iMemReadData,
    output logic [1:0]        oOwner
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;   // 0 = CPU, 1 = AUX
    logic             rd_done;
`ifndef ARB_CPU_PRIORITY_EN
    logic             ptr_q, ptr_d;       // preferred master on a tie: 0 = CPU, 1 = AUX
`endif

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
`ifndef ARB_CPU_PRIORITY_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
`ifndef ARB_CPU_PRIORITY_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Arbitration, memory-bus drive and next state
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        owner_d         = owner_q;
`ifndef ARB_CPU_PRIORITY_EN
        ptr_d           = ptr_q;
`endif
        oCpuReady       = 1'b0;
        oAuxReady       = 1'b0;
        rd_done         = 1'b0;
        oMemAddress     = '0;
        oMemWriteData   = '0;
        oMemByteEnable  = '0;
        oMemWriteEnable = 1'b0;
        oMemReadEnable  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grants are suppressed while reset is held so nothing is accepted
`ifdef ARB_CPU_PRIORITY_EN
                oCpuReady = ~iRST & iCpuReq;
                oAuxReady = ~iRST & iAuxReq & ~iCpuReq;
`else
                if (iCpuReq && iAuxReq) begin
                    oCpuReady = ~iRST & ~ptr_q;
                    oAuxReady = ~iRST & ptr_q;
                end else begin
                    oCpuReady = ~iRST & iCpuReq;
                    oAuxReady = ~iRST & iAuxReq;
                end
`endif
                if (oCpuReady || oAuxReady) begin
                    oMemAddress     = oAuxReady ? iAuxAddr  : iCpuAddr;
                    oMemWriteData   = oAuxReady ? iAuxWData : iCpuWData;
                    oMemByteEnable  = oAuxReady ? iAuxBE    : iCpuBE;
                    oMemWriteEnable = oAuxReady ? iAuxWrite : iCpuWrite;
                    oMemReadEnable  = ~oMemWriteEnable;
`ifndef ARB_CPU_PRIORITY_EN
                    // Prefer the master that did not just win
                    ptr_d = oCpuReady;
`endif
                    if (oMemReadEnable) begin
                        state_d = S_RD_WAIT;
                        cnt_d   = CNT_W'(READ_LATENCY);
                        owner_d = oAuxReady;
                    end
                end
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rd_done = 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read return steered to the latched owner only
    assign oCpuRValid = rd_done & ~owner_q;
    assign oAuxRValid = rd_done & owner_q;
    assign oCpuRData  = oCpuRValid ? iMemReadData : 32'd0;
    assign oAuxRData  = oAuxRValid ? iMemReadData : 32'd0;

    assign oCpuStall  = (iCpuReq & ~oCpuReady)
                      | ((state_q == S_RD_WAIT) & ~owner_q & ~oCpuRValid);

    assign oOwner     = (state_q != S_RD_WAIT) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule
